// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the MASTER_ALU; optional perf counters behind ALU_PERF_CNT_EN.
// Latency accept->wb_valid: 2 cycles (MUL: MUL_LAT+1); condition-failed/illegal ops retire after 1.
// One op in flight; in_ready low from accept until the writeback beat is taken; wb_ready stalls forever.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned RD_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opcode,
  input  logic [3:0]      in_cond,
  input  logic            in_s,
  input  logic [RD_W-1:0] in_rd,
  input  logic [31:0]     in_op1,
  input  logic [31:0]     in_op2,
  input  logic [15:0]     in_iv,
  output logic [3:0]      alu_opcode,
  output logic [31:0]     alu_reg1,
  output logic [31:0]     alu_reg2,
  output logic [15:0]     alu_iv,
  output logic [3:0]      alu_cond,
  output logic            alu_s,
  output logic [3:0]      alu_flag,
  input  logic [31:0]     alu_result,
  input  logic [3:0]      alu_new_flag,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic [3:0]      flags,
  output logic            illegal,
  output logic            busy
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_exec,
  output logic [31:0]     perf_skip
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_MOVN = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1011;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       via_exec;
  logic       accept, illegal_op, go_exec, capture, set_flags;

  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, p;
    {n, z, c, v} = f;
    p = 1'b0;
    case (cc)
      4'h0: p = 1'b1;
      4'h1: p = z;
      4'h2: p = !z;
      4'h3: p = c;
      4'h4: p = !c;
      4'h5: p = n;
      4'h6: p = !n;
      4'h7: p = v;
      4'h8: p = !v;
      4'h9: p = c && !z;
      4'hA: p = !c || z;
      4'hB: p = (n == v);
      4'hC: p = (n != v);
      4'hD: p = !z && (n == v);
      4'hE: p = z || (n != v);
      4'hF: p = 1'b0;
    endcase
    return p;
  endfunction

  assign accept     = in_valid && (state == IDLE);
  assign illegal_op = (in_opcode[3:2] == 2'b11);
  assign go_exec    = accept && !illegal_op && cond_pass(in_cond, flags);
  assign capture    = (state == EXEC) && (cnt == 4'd1);
  // CMP always writes flags; the move ops never do, even with S set.
  assign set_flags  = (alu_s || alu_opcode == OP_CMP) &&
                      (alu_opcode != OP_MOVN) && (alu_opcode != OP_MOV);
  assign alu_flag   = flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wb_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = go_exec ? EXEC : WB;
      end
      EXEC: if (cnt == 4'd1) state_nxt = WB;
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_reg1   <= '0;
      alu_reg2   <= '0;
      alu_iv     <= '0;
      alu_cond   <= '0;
      alu_s      <= 1'b0;
      cnt        <= '0;
      via_exec   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      flags      <= '0;
      illegal    <= 1'b0;
    end else begin
      illegal <= accept && illegal_op;
      if (accept) begin
        wb_rd    <= in_rd;
        via_exec <= go_exec;
        wb_we    <= 1'b0;
        wb_data  <= '0;
        if (go_exec) begin
          alu_opcode <= in_opcode;
          alu_reg1   <= in_op1;
          alu_reg2   <= in_op2;
          alu_iv     <= in_iv;
          alu_cond   <= in_cond;
          alu_s      <= in_s;
          cnt        <= (in_opcode == OP_MUL) ? MUL_CNT : 4'd1;
        end
      end
      if (state == EXEC) cnt <= cnt - 4'd1;
      if (capture) begin
        wb_data <= alu_result;
        wb_we   <= (alu_opcode != OP_CMP);
        if (set_flags) flags <= alu_new_flag;
      end
    end
  end

`ifdef ALU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_exec <= '0;
      perf_skip <= '0;
    end else if (wb_valid && wb_ready) begin
      if (via_exec) perf_exec <= perf_exec + 32'd1;
      else          perf_skip <= perf_skip + 32'd1;
    end
  end
`endif

endmodule
